vga_frame_scheduler: RTL and testbench

// - Master raster scheduler for the 800x600@60 display path (clk = 40 MHz).
// - Owns the horizontal and vertical counters and produces registered hsync/vsync/display.
// - Prefetches one sample-RAM word per active pixel.
// - Arbitrates the display/capture double-buffer swap, granting it only at frame end.

---
 rtl/vga_timing_pkg.sv | 31 +++
 rtl/vga_axis_counter.sv | 34 +++
 rtl/vga_frame_scheduler.sv | 106 ++++++++++
 tb/tb_vga_frame_scheduler.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Raster timing constants and helpers shared by the VGA frame scheduler blocks.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE = 800;
  localparam int unsigned H_FP     = 40;
  localparam int unsigned H_SYNC   = 128;
  localparam int unsigned H_BP     = 88;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_ACTIVE = 600;
  localparam int unsigned V_FP     = 1;
  localparam int unsigned V_SYNC   = 4;
  localparam int unsigned V_BP     = 23;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

  localparam int unsigned H_W    = 11;
  localparam int unsigned V_W    = 10;
  localparam int unsigned ADDR_W = 10;

  // Inclusive window test used by the sync decoders.
  function automatic logic in_range(input int unsigned v, input int unsigned lo,
                                    input int unsigned hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrap counter for one raster axis: counts 0..TOTAL-1, resets to TOTAL-1 so the
// first enabled clock after reset lands on 0.
module vga_axis_counter #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned TOTAL = 1056
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] next_c,
  output logic             last_c
);

  assign last_c = (count == WIDTH'(TOTAL - 1));

  // Next count: hold when disabled, wrap after the last position.
  always_comb begin
    next_c = count;
    if (en) begin
      next_c = last_c ? '0 : count + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= WIDTH'(TOTAL - 1);
    end else begin
      count <= next_c;
    end
  end

endmodule

// File: rtl/vga_frame_scheduler.sv
// Raster master: h/v counters, registered sync/display decode, one-clock-ahead
// sample-RAM prefetch and a frame-end-only display/capture bank swap arbiter.
module vga_frame_scheduler #(
  parameter int unsigned H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_timing_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_timing_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_timing_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_timing_pkg::V_BP,
  parameter int unsigned ADDR_W   = vga_timing_pkg::ADDR_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             swap_req,
  output logic                             swap_ack,
  output logic                             disp_bank,
  output logic                             rd_en,
  output logic [ADDR_W:0]                  rd_addr,
  output logic [vga_timing_pkg::H_W-1:0]   pixel_x,
  output logic [vga_timing_pkg::V_W-1:0]   line_y,
  output logic                             hsync,
  output logic                             vsync,
  output logic                             display,
  output logic                             line_start,
  output logic                             frame_start
);

  import vga_timing_pkg::*;

  localparam int unsigned HTOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_LO = H_ACTIVE + H_FP;
  localparam int unsigned HS_HI = HS_LO + H_SYNC - 1;
  localparam int unsigned VS_LO = V_ACTIVE + V_FP;
  localparam int unsigned VS_HI = VS_LO + V_SYNC - 1;

  logic [H_W-1:0] hc;
  logic [H_W-1:0] hc_nxt;
  logic           h_last;
  logic [V_W-1:0] vc;
  logic [V_W-1:0] vc_nxt;
  logic           v_last;

  logic frame_end_c;
  logic grant_c;
  logic bank_nxt_c;
  logic active_nxt_c;

  vga_axis_counter #(.WIDTH(H_W), .TOTAL(HTOT)) u_h (
    .clk    (clk),
    .rst    (rst),
    .en     (1'b1),
    .count  (hc),
    .next_c (hc_nxt),
    .last_c (h_last)
  );

  vga_axis_counter #(.WIDTH(V_W), .TOTAL(VTOT)) u_v (
    .clk    (clk),
    .rst    (rst),
    .en     (h_last),
    .count  (vc),
    .next_c (vc_nxt),
    .last_c (v_last)
  );

  // Swap grant only at the last pixel of the frame; prefetch targets the next point.
  always_comb begin
    frame_end_c  = h_last & v_last;
    grant_c      = frame_end_c & swap_req;
    bank_nxt_c   = disp_bank ^ grant_c;
    active_nxt_c = (hc_nxt < H_W'(H_ACTIVE)) && (vc_nxt < V_W'(V_ACTIVE));
  end

  // Output point is the counter position one clock late; prefetch runs one clock ahead of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      swap_ack    <= 1'b0;
      disp_bank   <= 1'b0;
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      pixel_x     <= '0;
      line_y      <= '0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      display     <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      swap_ack    <= grant_c;
      disp_bank   <= bank_nxt_c;
      rd_en       <= active_nxt_c;
      rd_addr     <= {bank_nxt_c, hc_nxt[ADDR_W-1:0]};
      pixel_x     <= hc;
      line_y      <= vc;
      hsync       <= in_range(32'(hc), HS_LO, HS_HI);
      vsync       <= in_range(32'(vc), VS_LO, VS_HI);
      display     <= (hc < H_W'(H_ACTIVE)) && (vc < V_W'(V_ACTIVE));
      line_start  <= (hc == '0);
      frame_start <= (hc == '0) && (vc == '0);
    end
  end

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Bench for vga_frame_scheduler: a shrunk-timing instance exercises whole frames
// and bank swaps, a default-timing instance checks real 800x600 line timing.
module tb_vga_frame_scheduler;

  localparam int unsigned SHA = 16, SHFP = 4, SHS = 8, SHBP = 4;
  localparam int unsigned SVA = 6,  SVFP = 1, SVS = 2, SVBP = 2;
  localparam int unsigned SAW = 4;
  localparam int unsigned SHT = SHA + SHFP + SHS + SHBP;   // 32
  localparam int unsigned SVT = SVA + SVFP + SVS + SVBP;   // 11
  localparam int unsigned SF  = SHT * SVT;                 // 352
  localparam int unsigned DHT = 1056;
  localparam int unsigned DF  = 1056 * 628;

  logic clk = 1'b0;
  logic rst;
  logic swap_req;

  logic        s_ack, s_bank, s_rd_en, s_hs, s_vs, s_disp, s_ls, s_fs;
  logic [4:0]  s_rd_addr;
  logic [10:0] s_px;
  logic [9:0]  s_ly;
  logic        d_ack, d_bank, d_rd_en, d_hs, d_vs, d_disp, d_ls, d_fs;
  logic [10:0] d_rd_addr;
  logic [10:0] d_px;
  logic [9:0]  d_ly;

  logic [39:0] obs_s, obs_d;
  assign obs_s = {s_ack, s_bank, s_rd_en, 6'd0, s_rd_addr, s_px, s_ly, s_hs, s_vs, s_disp, s_ls, s_fs};
  assign obs_d = {d_ack, d_bank, d_rd_en, d_rd_addr, d_px, d_ly, d_hs, d_vs, d_disp, d_ls, d_fs};

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference state: edges since reset release and per-instance bank/ack expectations.
  int unsigned n = 0;
  logic bank_s = 1'b0, bank_d = 1'b0, ack_s = 1'b0, ack_d = 1'b0;
  int unsigned ack_cnt_s = 0;
  int unsigned fs_last_s = 0, ls_last_d = 0, vs_run = 0, hs_run = 0;
  logic vs_prev = 1'b0, hs_prev = 1'b0;

  always #5 clk = ~clk;

  vga_frame_scheduler #(
    .H_ACTIVE(SHA), .H_FP(SHFP), .H_SYNC(SHS), .H_BP(SHBP),
    .V_ACTIVE(SVA), .V_FP(SVFP), .V_SYNC(SVS), .V_BP(SVBP), .ADDR_W(SAW)
  ) u_s (
    .clk(clk), .rst(rst), .swap_req(swap_req), .swap_ack(s_ack), .disp_bank(s_bank),
    .rd_en(s_rd_en), .rd_addr(s_rd_addr), .pixel_x(s_px), .line_y(s_ly),
    .hsync(s_hs), .vsync(s_vs), .display(s_disp), .line_start(s_ls), .frame_start(s_fs)
  );

  vga_frame_scheduler u_d (
    .clk(clk), .rst(rst), .swap_req(swap_req), .swap_ack(d_ack), .disp_bank(d_bank),
    .rd_en(d_rd_en), .rd_addr(d_rd_addr), .pixel_x(d_px), .line_y(d_ly),
    .hsync(d_hs), .vsync(d_vs), .display(d_disp), .line_start(d_ls), .frame_start(d_fs)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs after the n-th edge since release, from the raster arithmetic alone.
  function automatic logic [39:0] expect_vec(
      input int unsigned ha, input int unsigned hfp, input int unsigned hsw, input int unsigned hbp,
      input int unsigned va, input int unsigned vfp, input int unsigned vsw, input int unsigned vbp,
      input int unsigned aw, input int unsigned edges, input logic bank, input logic ack);
    int unsigned ht, vt, f, po, pi, x, y, xi, yi;
    logic hs, vs, disp, ls, fs, re;
    logic [10:0] ra;
    if (edges == 0) return '0;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    f  = ht * vt;
    po = (edges + f - 2) % f;
    pi = (edges - 1) % f;
    x  = po % ht;  y  = po / ht;
    xi = pi % ht;  yi = pi / ht;
    hs   = (x >= ha + hfp) && (x <= ha + hfp + hsw - 1);
    vs   = (y >= va + vfp) && (y <= va + vfp + vsw - 1);
    disp = (x < ha) && (y < va);
    ls   = (x == 0);
    fs   = (x == 0) && (y == 0);
    re   = (xi < ha) && (yi < va);
    ra   = 11'((bank ? (32'd1 << aw) : 32'd0) + (xi % (32'd1 << aw)));
    return {ack, bank, re, ra, 11'(x), 10'(y), hs, vs, disp, ls, fs};
  endfunction

  // One clock: update the reference at the edge, then compare away from it.
  task automatic tick();
    logic req;
    @(posedge clk);
    req = swap_req;
    if (rst) begin
      n = 0; bank_s = 1'b0; bank_d = 1'b0; ack_s = 1'b0; ack_d = 1'b0;
      fs_last_s = 0; ls_last_d = 0; vs_run = 0; hs_run = 0; vs_prev = 1'b0; hs_prev = 1'b0;
    end else begin
      n++;
      ack_s = req && ((n - 1) % SF == 0);
      if (ack_s) bank_s = !bank_s;
      ack_d = req && ((n - 1) % DF == 0);
      if (ack_d) bank_d = !bank_d;
    end
    #1;
    check("stream_small", obs_s, expect_vec(SHA, SHFP, SHS, SHBP, SVA, SVFP, SVS, SVBP, SAW, n, bank_s, ack_s));
    check("stream_default", obs_d, expect_vec(800, 40, 128, 88, 600, 1, 4, 23, 10, n, bank_d, ack_d));
    if (!rst) begin
      if (s_ack) ack_cnt_s++;
      if (s_fs) begin
        if (fs_last_s != 0) check("frame_start_period", n - fs_last_s, SF);
        fs_last_s = n;
      end
      if (s_vs && !vs_prev) check("vsync_first_line", s_ly, SVA + SVFP);
      if (s_vs) vs_run++;
      else if (vs_run != 0) begin
        check("vsync_width", vs_run, SVS * SHT);
        vs_run = 0;
      end
      vs_prev = s_vs;
      if (d_ls) begin
        if (ls_last_d != 0) check("line_start_period", n - ls_last_d, DHT);
        ls_last_d = n;
      end
      if (d_hs && !hs_prev) check("hsync_first_x", d_px, 840);
      if (d_hs) hs_run++;
      else if (hs_run != 0) begin
        check("hsync_width", hs_run, 128);
        hs_run = 0;
      end
      hs_prev = d_hs;
    end
  endtask

  task automatic wait_ack();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 3 * SF; i++) begin
      tick();
      if (s_ack) begin
        got = 1'b1;
        break;
      end
    end
    check("ack_seen", got, 1);
  endtask

  task automatic wait_line_s(input int unsigned line);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 2 * SF; i++) begin
      tick();
      if (s_ly == 10'(line) && s_px == 11'd5) begin
        got = 1'b1;
        break;
      end
    end
    check("reached_line", got, 1);
  endtask

  task automatic startup_checks();
    tick();
    check("first_rd_en_d", d_rd_en, 1);
    check("first_rd_addr_d", d_rd_addr, 0);
    check("first_rd_en_s", s_rd_en, 1);
    check("first_rd_addr_s", s_rd_addr, 0);
    tick();
    check("second_px_d", d_px, 0);
    check("second_ly_d", d_ly, 0);
    check("second_fs_d", d_fs, 1);
    check("second_disp_d", d_disp, 1);
    check("second_fs_s", s_fs, 1);
    check("second_bank_s", s_bank, 0);
  endtask

  initial begin
    logic b0, nb;
    int unsigned a0;
    rst = 1'b1;
    swap_req = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    startup_checks();

    // Plain raster: two-plus default lines, several shrunk frames.
    repeat (2200) tick();

    // Mid-frame request granted at frame end; (0,0) prefetch already on the new bank.
    wait_line_s(3);
    b0 = bank_s;
    nb = ~b0;
    swap_req = 1'b1;
    wait_ack();
    swap_req = 1'b0;
    check("swap_bank_toggle", s_bank, nb);
    check("swap_prefetch_addr", s_rd_addr, {nb, 4'b0000});
    check("swap_prefetch_en", s_rd_en, 1);
    check("swap_at_frame_end", (n - 1) % SF, 0);

    // Held request across two frame ends: two grants, bank back where it was.
    b0 = bank_s;
    a0 = ack_cnt_s;
    swap_req = 1'b1;
    wait_ack();
    wait_ack();
    swap_req = 1'b0;
    check("two_acks", ack_cnt_s - a0, 2);
    check("bank_restored", s_bank, b0);

    // No request: no grant across two frame ends, bank held.
    b0 = bank_s;
    a0 = ack_cnt_s;
    repeat (2 * SF) tick();
    check("no_req_no_ack", ack_cnt_s - a0, 0);
    check("no_req_bank_held", s_bank, b0);

    // Request rising in the frame-end cycle itself is granted on that edge.
    for (int i = 0; i < 2 * SF && ((n - 1) % SF != SF - 1); i++) tick();
    nb = ~bank_s;
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    check("same_cycle_grant", s_ack, 1);
    check("same_cycle_bank", s_bank, nb);

    // Randomised requester that drops its request after each grant.
    for (int i = 0; i < 3000; i++) begin
      if (s_ack) swap_req = 1'b0;
      else if (!swap_req && $urandom_range(0, 299) == 0) swap_req = 1'b1;
      tick();
    end
    swap_req = 1'b0;

    // Reset mid-frame with a pending request: immediate clear, no grant, clean restart.
    wait_line_s(3);
    swap_req = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("rst_async_small", obs_s, 0);
    check("rst_async_default", obs_d, 0);
    repeat (4) begin
      tick();
      check("rst_no_ack", s_ack, 0);
    end
    swap_req = 1'b0;
    rst = 1'b0;
    startup_checks();
    repeat (400) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
